// File: rtl/poly_synthesizer.sv
// poly_synthesizer: key-to-voice allocator with stealing, phase-accumulator voices, waveform mixer and PWM output
module poly_synthesizer #(
    parameter int NUM_KEYS   = 17,
    parameter int NUM_VOICES = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int BASE_STEP  = 256,
    parameter int STEP_INC   = 16,
    parameter int SAMPLE_DIV = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_KEYS-1:0]   keys,
    input  logic [1:0]            mode,
    output logic [OUT_WIDTH-1:0]  sample,
    output logic                  pwm_out,
    output logic [NUM_VOICES-1:0] voice_active
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int VI = (VW > 0) ? VW : 1;
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int SW = OUT_WIDTH + VW;

    logic [NUM_KEYS-1:0] s1_q, s2_q, s3_q, pon_q, pon_d, poff_q, poff_d;
    logic [NUM_VOICES-1:0] act_q, act_d;
    logic [NUM_VOICES-1:0][KW-1:0] own_q, own_d;
    logic [NUM_VOICES-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [VI-1:0] steal_q, steal_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [OUT_WIDTH-1:0] cnt_q, cnt_d, sample_q, sample_d;
    logic [1:0] warm_q, warm_d;
    logic pwm_q, pwm_d;

    logic [NUM_KEYS-1:0] rise, fall, on_elig;
    logic svc_off, svc_on, owned, any_free, tick;
    logic [KW-1:0] off_k, on_k;
    logic [VI-1:0] free_v;
    logic [OUT_WIDTH-1:0] vval;
    logic [SW-1:0] sum;

    always_comb begin
        // edges are ignored until s3 holds a sample taken after reset release
        warm_d = (&warm_q) ? warm_q : warm_q + 2'd1;
        rise = s2_q & ~s3_q & {NUM_KEYS{&warm_q}};
        fall = s3_q & ~s2_q & {NUM_KEYS{&warm_q}};
        on_elig = pon_q & ~fall;
        svc_off = |poff_q;
        svc_on = !svc_off && (|on_elig);
        off_k = '0;
        on_k = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (poff_q[k]) off_k = KW'(k);
            if (on_elig[k]) on_k = KW'(k);
        end
        pon_d = pon_q;
        poff_d = poff_q;
        if (svc_off) poff_d[off_k] = 1'b0;
        if (svc_on) pon_d[on_k] = 1'b0;
        pon_d = (pon_d | rise) & ~fall;
        poff_d = poff_d | (fall & ~pon_q);
        tick = pre_q == PW'(SAMPLE_DIV - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
        owned = 1'b0;
        any_free = 1'b0;
        free_v = '0;
        vval = '0;
        sum = '0;
        act_d = act_q;
        own_d = own_q;
        steal_d = steal_q;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            vval = (mode == 2'b00) ? {OUT_WIDTH{acc_q[v][ACC_WIDTH-1]}}
                 : (mode == 2'b01) ? acc_q[v][ACC_WIDTH-1 -: OUT_WIDTH]
                 : (mode == 2'b10) ? acc_q[v][ACC_WIDTH-2 -: OUT_WIDTH] ^ {OUT_WIDTH{acc_q[v][ACC_WIDTH-1]}}
                 : '0;
            if (act_q[v]) sum = sum + SW'(vval);
            acc_d[v] = acc_q[v] + ((tick && act_q[v]) ? ACC_WIDTH'(BASE_STEP + int'(own_q[v]) * STEP_INC) : '0);
            if (act_q[v] && own_q[v] == on_k) owned = 1'b1;
            if (!act_q[v]) begin
                any_free = 1'b1;
                free_v = VI'(v);
            end
            if (svc_off && act_q[v] && own_q[v] == off_k) begin
                act_d[v] = 1'b0;
                acc_d[v] = '0;
            end
        end
        if (svc_on && !owned) begin
            if (any_free) begin
                act_d[free_v] = 1'b1;
                own_d[free_v] = on_k;
                acc_d[free_v] = '0;
            end else begin
                own_d[steal_q] = on_k;
                acc_d[steal_q] = '0;
                steal_d = (NUM_VOICES > 1) ? steal_q + 1'b1 : '0;
            end
        end
        sample_d = tick ? OUT_WIDTH'(sum >> VW) : sample_q;
        cnt_d = cnt_q + 1'b1;
        pwm_d = cnt_q < sample_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            pon_q <= '0;
            poff_q <= '0;
            act_q <= '0;
            own_q <= '0;
            acc_q <= '0;
            steal_q <= '0;
            pre_q <= '0;
            cnt_q <= '0;
            sample_q <= '0;
            warm_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            s1_q <= keys;
            s2_q <= s1_q;
            s3_q <= s2_q;
            pon_q <= pon_d;
            poff_q <= poff_d;
            act_q <= act_d;
            own_q <= own_d;
            acc_q <= acc_d;
            steal_q <= steal_d;
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            sample_q <= sample_d;
            warm_q <= warm_d;
            pwm_q <= pwm_d;
        end
    end

    assign sample = sample_q;
    assign pwm_out = pwm_q;
    assign voice_active = act_q;
endmodule

// File: tb/tb_poly_synthesizer.sv
// tb_poly_synthesizer: randomized scoreboard bench for poly_synthesizer with a behavioural voice model
module tb_poly_synthesizer;
    localparam int NK = 17, NV = 4, A = 16, O = 8, BS = 256, SI = 16, SD = 4;

    logic clk = 1'b0, n_rst = 1'b0;
    logic [NK-1:0] keys = '0;
    logic [1:0] mode = 2'b00;
    logic [O-1:0] sample;
    logic pwm_out;
    logic [NV-1:0] voice_active;
    int checks = 0, errors = 0;

    typedef struct {int smp; int act; int pwm;} exp_t;
    exp_t q[$];

    logic [NK-1:0] samp[$];
    bit pon[NK], poff[NK], von[NV];
    int vkey[NV], vph[NV];
    int steal, presc, cnt, smp, pwm;

    poly_synthesizer dut (
        .clk(clk), .n_rst(n_rst), .keys(keys), .mode(mode),
        .sample(sample), .pwm_out(pwm_out), .voice_active(voice_active)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int wave(int ph, int m);
        int top, trv;
        bit hi;
        top = ph / (1 << (A - O));
        hi = ph >= (1 << (A - 1));
        trv = (ph / (1 << (A - 1 - O))) % (1 << O);
        case (m)
            0: return hi ? (1 << O) - 1 : 0;
            1: return top;
            2: return hi ? (1 << O) - 1 - trv : trv;
            default: return 0;
        endcase
    endfunction

    function automatic void mreset();
        samp.delete();
        for (int i = 0; i < NK; i++) begin
            pon[i] = 0;
            poff[i] = 0;
        end
        for (int v = 0; v < NV; v++) begin
            von[v] = 0;
            vkey[v] = 0;
            vph[v] = 0;
        end
        steal = 0; presc = 0; cnt = 0; smp = 0; pwm = 0;
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.smp = smp;
        e.pwm = pwm;
        e.act = 0;
        for (int v = 0; v < NV; v++) if (von[v]) e.act |= 1 << v;
        return e;
    endfunction

    function automatic void mstep(logic [NK-1:0] k, int m);
        bit rise[NK], fall[NK], was_on;
        bit tick;
        int sum, ev_off, ev_on, sz, owner, free;
        tick = presc == SD - 1;
        sum = 0; ev_off = -1; ev_on = -1; sz = samp.size();
        for (int i = 0; i < NK; i++) begin
            rise[i] = sz >= 3 && samp[sz-2][i] && !samp[sz-3][i];
            fall[i] = sz >= 3 && !samp[sz-2][i] && samp[sz-3][i];
        end
        for (int v = 0; v < NV; v++) if (von[v]) sum += wave(vph[v], m);
        for (int i = NK - 1; i >= 0; i--) begin
            if (poff[i]) ev_off = i;
            if (pon[i] && !fall[i]) ev_on = i;
        end
        if (ev_off >= 0) ev_on = -1;
        for (int i = 0; i < NK; i++) begin
            was_on = pon[i];
            if (i == ev_off) poff[i] = 0;
            if (i == ev_on) pon[i] = 0;
            if (rise[i]) pon[i] = 1;
            if (fall[i]) begin
                if (was_on) pon[i] = 0;
                else poff[i] = 1;
            end
        end
        for (int v = 0; v < NV; v++)
            if (tick && von[v]) vph[v] = (vph[v] + BS + vkey[v] * SI) % (1 << A);
        if (ev_off >= 0)
            for (int v = 0; v < NV; v++)
                if (von[v] && vkey[v] == ev_off) begin
                    von[v] = 0;
                    vph[v] = 0;
                end
        if (ev_on >= 0) begin
            owner = -1; free = -1;
            for (int v = NV - 1; v >= 0; v--) begin
                if (von[v] && vkey[v] == ev_on) owner = v;
                if (!von[v]) free = v;
            end
            if (owner < 0) begin
                if (free >= 0) begin
                    von[free] = 1; vkey[free] = ev_on; vph[free] = 0;
                end else begin
                    vkey[steal] = ev_on; vph[steal] = 0; steal = (steal + 1) % NV;
                end
            end
        end
        pwm = (cnt < smp) ? 1 : 0;
        cnt = (cnt + 1) % (1 << O);
        if (tick) smp = sum / NV;
        presc = tick ? 0 : presc + 1;
        samp.push_back(k);
        if (samp.size() > 3) void'(samp.pop_front());
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mreset();
            q.delete();
            q.push_back(snap());
        end else begin
            mstep(keys, int'(mode));
            q.push_back(snap());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sample", int'(sample), e.smp);
            check("voice_active", int'(voice_active), e.act);
            check("pwm_out", int'(pwm_out), e.pwm);
        end
    end

    task automatic step_clk(int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        step_clk(3);
        check("reset_sample", int'(sample), 0);
        check("reset_active", int'(voice_active), 0);
        n_rst = 1'b1;
        step_clk(5);
        keys[0] = 1'b1;
        step_clk(3);
        check("latency_before", int'(voice_active), 0);
        step_clk(1);
        check("latency_at4", int'(voice_active), 1);
        step_clk(800);
        check("square_high", int'(sample), 63);
        step_clk(280);
        check("square_low", int'(sample), 0);
        keys = '0;
        step_clk(10);
        check("release_free", int'(voice_active), 0);
        keys[3] = 1'b1;
        keys[5] = 1'b1;
        step_clk(4);
        check("pair_first", int'(voice_active), 1);
        step_clk(1);
        check("pair_second", int'(voice_active), 3);
        keys = '0;
        step_clk(10);
        keys = NK'(4'hF);
        step_clk(10);
        check("four_held", int'(voice_active), 15);
        keys[4] = 1'b1;
        step_clk(10);
        check("steal_v0", int'(voice_active), 15);
        keys[6] = 1'b1;
        step_clk(10);
        check("steal_v1", int'(voice_active), 15);
        keys[4] = 1'b0;
        step_clk(10);
        check("free_key4", int'(voice_active), 14);
        keys[6] = 1'b0;
        step_clk(10);
        check("free_key6", int'(voice_active), 12);
        keys[0] = 1'b0;
        step_clk(10);
        check("free_unowned", int'(voice_active), 12);
        keys = '0;
        step_clk(10);
        check("all_free", int'(voice_active), 0);
        keys[2] = 1'b1;
        step_clk(1);
        keys[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk(1);
            check("short_press", int'(voice_active), 0);
        end
        keys[7] = 1'b1;
        mode = 2'b01;
        step_clk(6);
        check("note_on", int'(voice_active), 1);
        step_clk(400);
        n_rst = 1'b0;
        #1;
        check("async_active", int'(voice_active), 0);
        check("async_sample", int'(sample), 0);
        check("async_pwm", int'(pwm_out), 0);
        step_clk(3);
        n_rst = 1'b1;
        step_clk(20);
        check("held_after_reset", int'(voice_active), 0);
        keys[7] = 1'b0;
        step_clk(5);
        keys[7] = 1'b1;
        step_clk(4);
        check("repress", int'(voice_active), 1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) keys[$urandom_range(NK - 1)] ^= 1'b1;
            if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(1499) == 0) begin
                n_rst = 1'b0;
                step_clk(2);
                n_rst = 1'b1;
            end
            step_clk(1);
        end
        keys = '0;
        step_clk(20);
        check("final_free", int'(voice_active), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/poly_synthesizer.md
POLY_SYNTHESIZER -- requirements
Module: poly_synthesizer

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 17: number of key inputs.
REQ-002 The block SHALL have parameter NUM_VOICES, default 4, a power of two from 1 to 8: number of simultaneous voices.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 16: phase accumulator width.
REQ-004 The block SHALL have parameter OUT_WIDTH, default 8, at most ACC_WIDTH-1: sample and PWM resolution.
REQ-005 The block SHALL have parameter BASE_STEP, default 256: phase step of key 0.
REQ-006 The block SHALL have parameter STEP_INC, default 16: phase step increment per key index.
REQ-007 The block SHALL have parameter SAMPLE_DIV, default 4, at least 2: clk cycles per sample tick.
REQ-008 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 Port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-010 Port keys, input, NUM_KEYS bits: asynchronous key levels, 1 means pressed.
REQ-011 Port mode, input, 2 bits: waveform select; 00 square, 01 saw, 10 triangle, 11 mute.
REQ-012 Port sample, output, OUT_WIDTH bits: registered mixed sample.
REQ-013 Port pwm_out, output, 1 bit: PWM rendering of sample.
REQ-014 Port voice_active, output, NUM_VOICES bits: bit v is 1 while voice v owns a key.

Function
REQ-015 Key path: each key SHALL pass through a 2-FF synchroniser and then a third history register; rise = s2 and not s3, fall = not s2 and s3.
REQ-016 Rise SHALL set pending_on[k]. Fall SHALL clear pending_on[k] if it is set; otherwise fall SHALL set pending_off[k].
REQ-017 Event service: at most one event per cycle. Any pending_off SHALL win over any pending_on; within each class, the lowest key index wins. Servicing clears that pending bit.
REQ-018 Off event for key k: the voice owning k SHALL be freed (active=0, accumulator=0). If no voice owns k, there is no effect.
REQ-019 On event for key k, when k already owns a voice: no effect.
REQ-020 On event for key k, when a voice is free: the lowest-index free voice SHALL take k, with active=1 and accumulator=0.
REQ-021 On event for key k, when all voices are busy: the voice at steal_ptr SHALL be reassigned to k with accumulator=0, and steal_ptr SHALL increment modulo NUM_VOICES.
REQ-022 Latency: with no other events pending, voice_active SHALL update exactly 4 clk edges after a key level change that meets setup.
REQ-023 Sample tick: a prescaler counting 0..SAMPLE_DIV-1 SHALL assert the tick for one cycle when the count equals SAMPLE_DIV-1, then wrap to 0.
REQ-024 Stepping: on each tick, every active voice accumulator SHALL add step(k) = BASE_STEP + k*STEP_INC, truncated to ACC_WIDTH and wrapping modulo 2^ACC_WIDTH.
REQ-025 A voice allocated in the same cycle as a tick SHALL start at 0, with no step applied that cycle.
REQ-026 Voice value, where t = acc[ACC_WIDTH-1 -: OUT_WIDTH]:
- square: all-ones if acc MSB = 1, else 0
- saw: t
- triangle: acc[ACC_WIDTH-2 -: OUT_WIDTH] if MSB = 0, else its bitwise inverse
- mute: 0
- inactive voices contribute 0.
REQ-027 Mix: sample SHALL update only on a tick, to (sum of all voice values) >> log2(NUM_VOICES). The sum SHALL use OUT_WIDTH+log2(NUM_VOICES) bits and never overflow. The values summed are those from before that tick's step, so output latency is 1 tick.
REQ-028 PWM: a free-running OUT_WIDTH-bit counter SHALL increment every clk; pwm_out = (counter < sample), registered.
REQ-029 A mode change SHALL take effect at the next tick and SHALL NOT alter accumulators.

Reset
REQ-030 n_rst low SHALL immediately clear:
- synchronisers, history registers, pending_on, pending_off
- voice ownership, voice_active, accumulators
- steal_ptr, prescaler, PWM counter
- sample and pwm_out (all to 0).
REQ-031 Keys held during reset release SHALL NOT generate rise events, because history resets to 0 and keys are sampled only after release; a key held low-to-high across release follows REQ-015.
REQ-032 Reset asserted mid-operation SHALL abandon all pending events; no voice SHALL be active on the first cycle after release.

Verification (defaults)
REQ-033 Press key 0 in square mode -> voice_active = 0001 after 4 clk; after 128 ticks, sample = 63; at tick 256, sample = 0.
REQ-034 Press keys 3 and 5 in the same cycle -> key 3 is assigned to voice 0 and key 5 to voice 1, one cycle apart; voice_active = 0011.
REQ-035 Hold keys 0..3, then press key 4 -> voice 0 is reassigned to key 4 and steal_ptr = 1; pressing key 6 afterwards steals voice 1.
REQ-036 Press key 2 and release it before the rise is serviced -> no voice is ever allocated and no pending bits remain.
REQ-037 Saw mode, single voice: sample tracks t>>2 with a lag of 1 tick; pwm_out high for exactly sample cycles of every 256-cycle window.
REQ-038 Pulse n_rst low mid-note -> sample = 0, pwm_out = 0 and voice_active = 0 asynchronously; a key still held after release allocates no voice until it is re-pressed.
